// File: rtl/ebus_receiver.sv
// EBUS receive path: registered byte pins -> MS-lane-first word assembler -> show-ahead word FIFO; last byte at edge N gives rx_valid after N+2.
// Backpressure: rx_ready pops, registered ebus_hold keeps one entry of slack, pushes into a full FIFO are dropped (rx_overflow); `EBUS_RX_PARITY_EN adds odd-parity checking.
module ebus_receiver #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int EBUS_DATA_SIZE = 8
) (
  input  logic                                     clock,
  input  logic                                     reset_l,
  input  logic [EBUS_DATA_SIZE-1:0]                ebus_data,
  input  logic                                     ebus_strobe,
  input  logic                                     ebus_last,
`ifdef EBUS_RX_PARITY_EN
  input  logic                                     ebus_parity,
  output logic                                     rx_parity_err,
`endif
  output logic                                     ebus_hold,
  output logic [BYTES_PER_WORD*EBUS_DATA_SIZE-1:0] rx_data,
  output logic [2:0]                               rx_count,
  output logic                                     rx_last,
  output logic                                     rx_valid,
  input  logic                                     rx_ready,
  input  logic                                     rx_clear,
  output logic                                     rx_overflow
);

  localparam int DW = EBUS_DATA_SIZE;
  localparam int WW = BYTES_PER_WORD * EBUS_DATA_SIZE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0]    BPW_L   = 3'(BYTES_PER_WORD);
  localparam logic [AW:0]   DEPTH_L = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   OCC_ONE = 1;
  localparam logic [AW:0]   OCC_TWO = 2;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_ASSEMBLE, S_PUSH} state_t;

  logic [DW-1:0]   in_data_q, in_data_d;
  logic            in_strobe_q, in_strobe_d;
  logic            in_last_q, in_last_d;

  state_t          state_q, state_d;
  logic [WW-1:0]   word_q, word_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            last_q, last_d;

  logic [WW-1:0]   mem_data_q [FIFO_DEPTH];
  logic [WW-1:0]   mem_data_d [FIFO_DEPTH];
  logic [2:0]      mem_cnt_q  [FIFO_DEPTH];
  logic [2:0]      mem_cnt_d  [FIFO_DEPTH];
  logic            mem_last_q [FIFO_DEPTH];
  logic            mem_last_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic [AW:0]     free_d;
  logic            overflow_q, overflow_d;
  logic            hold_q, hold_d;

  logic            open_word, take_byte;
  logic [2:0]      cnt_inc;
  logic            push_req, push_ok, pop, full, overflow_set;

`ifdef EBUS_RX_PARITY_EN
  logic            in_parity_q, in_parity_d;
  logic            poison_q, poison_d;
  logic            parity_err_q, parity_err_d;
  logic            byte_bad;
`endif

  always_comb begin
    in_data_d   = ebus_data;
    in_strobe_d = ebus_strobe;
    in_last_d   = ebus_last;
`ifdef EBUS_RX_PARITY_EN
    in_parity_d = ebus_parity;
`endif
  end

  // Assembler: a strobe seen in IDLE or PUSH opens a fresh word in lane 0.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    open_word = 1'b0;
    take_byte = 1'b0;
    cnt_inc   = cnt_q + 3'd1;
    case (state_q)
      S_IDLE:     open_word = in_strobe_q;
      S_ASSEMBLE: take_byte = in_strobe_q;
      S_PUSH: begin
        open_word = in_strobe_q;
        state_d   = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
    if (open_word) begin
      word_d            = '0;
      word_d[WW-1 -: DW] = in_data_q;
      cnt_d             = 3'd1;
      last_d            = in_last_q;
      state_d           = (in_last_q || BPW_L == 3'd1) ? S_PUSH : S_ASSEMBLE;
    end else if (take_byte) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (cnt_q == 3'(i)) word_d[(BYTES_PER_WORD-1-i)*DW +: DW] = in_data_q;
      end
      cnt_d   = cnt_inc;
      last_d  = in_last_q;
      state_d = (in_last_q || cnt_inc == BPW_L) ? S_PUSH : S_ASSEMBLE;
    end
  end

`ifdef EBUS_RX_PARITY_EN
  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  assign byte_bad = ~(^in_data_q ^ in_parity_q);

  always_comb begin
    poison_d     = poison_q;
    parity_err_d = parity_err_q;
    if (open_word)      poison_d = byte_bad;
    else if (take_byte) poison_d = poison_q | byte_bad;
    if (state_q == S_PUSH && poison_q) parity_err_d = 1'b1;
    else if (rx_clear)                 parity_err_d = 1'b0;
  end

  assign push_req      = (state_q == S_PUSH) && !poison_q;
  assign rx_parity_err = parity_err_q;
`else
  assign push_req = (state_q == S_PUSH);
`endif

  assign rx_valid     = (occ_q != '0);
  assign full         = (occ_q == DEPTH_L);
  assign pop          = rx_valid && rx_ready;
  assign push_ok      = push_req && (!full || pop);
  assign overflow_set = push_req && full && !pop;

  // When full, a simultaneous pop frees the head slot, which is the write slot.
  always_comb begin
    mem_data_d = mem_data_q;
    mem_cnt_d  = mem_cnt_q;
    mem_last_d = mem_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      mem_data_d[wr_ptr_q] = word_q;
      mem_cnt_d[wr_ptr_q]  = cnt_q;
      mem_last_d[wr_ptr_q] = last_q;
      wr_ptr_d             = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
    if (overflow_set)  overflow_d = 1'b1;
    else if (rx_clear) overflow_d = 1'b0;
    free_d = DEPTH_L - occ_d;
    hold_d = (free_d <= ((state_d != S_IDLE) ? OCC_TWO : OCC_ONE));
  end

  always_ff @(posedge clock) begin
    if (!reset_l) begin
      in_data_q    <= '0;
      in_strobe_q  <= 1'b0;
      in_last_q    <= 1'b0;
      state_q      <= S_IDLE;
      word_q       <= '0;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      overflow_q   <= 1'b0;
      hold_q       <= 1'b0;
`ifdef EBUS_RX_PARITY_EN
      in_parity_q  <= 1'b0;
      poison_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      in_data_q    <= in_data_d;
      in_strobe_q  <= in_strobe_d;
      in_last_q    <= in_last_d;
      state_q      <= state_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      overflow_q   <= overflow_d;
      hold_q       <= hold_d;
`ifdef EBUS_RX_PARITY_EN
      in_parity_q  <= in_parity_d;
      poison_q     <= poison_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    mem_data_q <= mem_data_d;
    mem_cnt_q  <= mem_cnt_d;
    mem_last_q <= mem_last_d;
  end

  assign rx_data     = rx_valid ? mem_data_q[rd_ptr_q] : '0;
  assign rx_count    = rx_valid ? mem_cnt_q[rd_ptr_q]  : 3'd0;
  assign rx_last     = rx_valid ? mem_last_q[rd_ptr_q] : 1'b0;
  assign ebus_hold   = hold_q;
  assign rx_overflow = overflow_q;

endmodule

// File: tb/tb_ebus_receiver.sv
// Randomised and directed bench for ebus_receiver against a byte-stream packing model.
module tb_ebus_receiver;

  localparam int BPW = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  cnt;
    logic        last;
  } word_t;

  logic        clock;
  logic        reset_l;
  logic [7:0]  ebus_data;
  logic        ebus_strobe;
  logic        ebus_last;
  logic        ebus_hold;
  logic [31:0] rx_data;
  logic [2:0]  rx_count;
  logic        rx_last;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_clear;
  logic        rx_overflow;
  logic        bad_par;
`ifdef EBUS_RX_PARITY_EN
  logic        ebus_parity;
  logic        rx_parity_err;
`endif

  int errors = 0;
  int checks = 0;
  int hold_timeouts = 0;

  word_t       exp_q[$];
  word_t       got_q[$];
  logic [31:0] mdl_word;
  int          mdl_cnt;
  logic        mon_en;
  logic        send_done;
  logic        prev_stall;
  word_t       prev_w;

  ebus_receiver #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH), .EBUS_DATA_SIZE(8)) dut (
    .clock       (clock),
    .reset_l     (reset_l),
    .ebus_data   (ebus_data),
    .ebus_strobe (ebus_strobe),
    .ebus_last   (ebus_last),
`ifdef EBUS_RX_PARITY_EN
    .ebus_parity (ebus_parity),
    .rx_parity_err(rx_parity_err),
`endif
    .ebus_hold   (ebus_hold),
    .rx_data     (rx_data),
    .rx_count    (rx_count),
    .rx_last     (rx_last),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_clear    (rx_clear),
    .rx_overflow (rx_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Packing rule: byte k of a word lands in lane k counted from the MS end.
  task automatic mdl_reset();
    mdl_word = 32'h0;
    mdl_cnt  = 0;
  endtask

  task automatic mdl_byte(input logic [7:0] d, input logic l);
    word_t w;
    mdl_word = mdl_word | ({24'h0, d} << (8 * (BPW - 1 - mdl_cnt)));
    mdl_cnt++;
    if (l || mdl_cnt == BPW) begin
      w.data = mdl_word;
      w.cnt  = 3'(mdl_cnt);
      w.last = l;
      exp_q.push_back(w);
      mdl_word = 32'h0;
      mdl_cnt  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    ebus_data   = d;
    ebus_strobe = 1'b1;
    ebus_last   = l;
`ifdef EBUS_RX_PARITY_EN
    ebus_parity = ~(^d) ^ bad_par;
`endif
    tick();
    ebus_strobe = 1'b0;
    ebus_last   = 1'b0;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (prev_stall) begin
        checks++;
        if ({rx_data, rx_count, rx_last} !== prev_w) begin
          errors++;
          $display("FAIL head_stable got=%h exp=%h", {rx_data, rx_count, rx_last}, prev_w);
        end
      end
      if (rx_valid && rx_ready) got_q.push_back({rx_data, rx_count, rx_last});
      prev_stall = rx_valid && !rx_ready;
      prev_w     = {rx_data, rx_count, rx_last};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic test_reset();
    reset_l = 1'b0;
    tick();
    tick();
    checks++;
    if ({rx_valid, rx_count, rx_last, ebus_hold, rx_overflow, rx_data} !== 39'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {rx_valid, rx_count, rx_last, ebus_hold, rx_overflow, rx_data});
    end
`ifdef EBUS_RX_PARITY_EN
    checks++;
    if (rx_parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_parity_err got=%b exp=0", rx_parity_err);
    end
`endif
    reset_l = 1'b1;
    tick();
  endtask

  task automatic test_word_latency();
    logic [7:0] b [4];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
    rx_ready = 1'b1;
    mdl_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      send_byte(b[i], 1'b0);
      mdl_byte(b[i], 1'b0);
    end
    tick();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got=%b exp=0", rx_valid);
    end
    tick();
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_valid got=%b exp=1", rx_valid);
    end
    checks++;
    if ({rx_data, rx_count, rx_last} !== {32'h11223344, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL word_1234 got=%h/%0d/%b exp=11223344/4/0", rx_data, rx_count, rx_last);
    end
    checks++;
    if ({rx_data, rx_count, rx_last} !== exp_q[0]) begin
      errors++;
      $display("FAIL word_1234_model got=%h exp=%h", {rx_data, rx_count, rx_last}, exp_q[0]);
    end
    tick();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_empties got=%b exp=0", rx_valid);
    end
  endtask

  task automatic test_short_transfer();
    rx_ready = 1'b1;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    tick();
    tick();
    checks++;
    if ({rx_valid, rx_data, rx_count, rx_last} !== {1'b1, 32'hAABB0000, 3'd2, 1'b1}) begin
      errors++;
      $display("FAIL short_word got=%b/%h/%0d/%b exp=1/aabb0000/2/1",
               rx_valid, rx_data, rx_count, rx_last);
    end
    tick();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
    tick();
    tick();
    checks++;
    if ({rx_valid, rx_data, rx_count, rx_last} !== {1'b1, 32'h01020304, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL after_short_idle got=%b/%h/%0d/%b exp=1/01020304/4/0",
               rx_valid, rx_data, rx_count, rx_last);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic       hold_w1;
    logic       hold_by3;
    logic [7:0] d;
    rx_ready = 1'b0;
    mdl_reset();
    exp_q.delete();
    hold_w1  = 1'b0;
    hold_by3 = 1'b0;
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < BPW; b++) begin
        if (w == 0 && ebus_hold) hold_w1 = 1'b1;
        if (w <= 2 && ebus_hold) hold_by3 = 1'b1;
        d = 8'($urandom);
        send_byte(d, 1'b0);
        if (w < 4) mdl_byte(d, 1'b0);
      end
    end
    tick();
    tick();
    tick();
    checks++;
    if (hold_w1 !== 1'b0) begin
      errors++;
      $display("FAIL hold_early got=%b exp=0", hold_w1);
    end
    checks++;
    if (hold_by3 !== 1'b1) begin
      errors++;
      $display("FAIL hold_by_word3 got=%b exp=1", hold_by3);
    end
    checks++;
    if (rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got=%b exp=1", rx_overflow);
    end
    rx_clear = 1'b1;
    tick();
    rx_clear = 1'b0;
    checks++;
    if (rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear got=%b exp=0", rx_overflow);
    end
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rx_valid, rx_data, rx_count, rx_last} !== {1'b1, exp_q[i]}) begin
        errors++;
        $display("FAIL ovf_pop%0d got=%b/%h exp=1/%h", i, rx_valid,
                 {rx_data, rx_count, rx_last}, exp_q[i]);
      end
      tick();
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_word5_dropped got=%b exp=0", rx_valid);
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] d;
    rx_ready = 1'b0;
    mdl_reset();
    exp_q.delete();
    for (int i = 0; i < 4 * BPW; i++) begin
      d = 8'($urandom);
      send_byte(d, 1'b0);
      mdl_byte(d, 1'b0);
    end
    for (int i = 0; i < BPW; i++) begin
      d = 8'($urandom);
      send_byte(d, 1'b0);
      mdl_byte(d, 1'b0);
    end
    tick();
    checks++;
    if ({rx_valid, ebus_hold, rx_data, rx_count, rx_last} !== {2'b11, exp_q[0]}) begin
      errors++;
      $display("FAIL full_head got=%b%b/%h exp=11/%h", rx_valid, ebus_hold,
               {rx_data, rx_count, rx_last}, exp_q[0]);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_no_overflow got=%b exp=0", rx_overflow);
    end
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rx_valid, rx_data, rx_count, rx_last} !== {1'b1, exp_q[i]}) begin
        errors++;
        $display("FAIL full_pop%0d got=%b/%h exp=1/%h", i, rx_valid,
                 {rx_data, rx_count, rx_last}, exp_q[i]);
      end
      tick();
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_occupancy4 got=%b exp=0", rx_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    rx_ready = 1'b0;
    for (int i = 0; i < BPW + 2; i++) send_byte(8'($urandom), 1'b0);
    reset_l = 1'b0;
    tick();
    reset_l = 1'b1;
    checks++;
    if ({rx_valid, rx_count, rx_last, ebus_hold, rx_overflow, rx_data} !== 39'h0) begin
      errors++;
      $display("FAIL midreset_outputs got=%h exp=0",
               {rx_valid, rx_count, rx_last, ebus_hold, rx_overflow, rx_data});
    end
    rx_ready = 1'b1;
    mdl_reset();
    exp_q.delete();
    for (int i = 0; i < BPW; i++) begin
      d = 8'($urandom);
      send_byte(d, 1'b0);
      mdl_byte(d, 1'b0);
    end
    tick();
    tick();
    checks++;
    if ({rx_valid, rx_data, rx_count, rx_last} !== {1'b1, exp_q[0]}) begin
      errors++;
      $display("FAIL midreset_clean_word got=%b/%h exp=1/%h", rx_valid,
               {rx_data, rx_count, rx_last}, exp_q[0]);
    end
    tick();
  endtask

`ifdef EBUS_RX_PARITY_EN
  task automatic test_parity();
    rx_ready = 1'b1;
    send_byte(8'h10, 1'b0);
    bad_par = 1'b1;
    send_byte(8'h20, 1'b0);
    bad_par = 1'b0;
    send_byte(8'h30, 1'b0);
    send_byte(8'h40, 1'b0);
    tick();
    tick();
    tick();
    checks++;
    if ({rx_valid, rx_parity_err} !== 2'b01) begin
      errors++;
      $display("FAIL parity_drop got=%b%b exp=01", rx_valid, rx_parity_err);
    end
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    tick();
    tick();
    checks++;
    if ({rx_valid, rx_data, rx_count} !== {1'b1, 32'h55667788, 3'd4}) begin
      errors++;
      $display("FAIL parity_next_word got=%b/%h/%0d exp=1/55667788/4",
               rx_valid, rx_data, rx_count);
    end
    tick();
    rx_clear = 1'b1;
    tick();
    rx_clear = 1'b0;
    checks++;
    if (rx_parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_clear got=%b exp=0", rx_parity_err);
    end
  endtask
`endif

  task automatic test_random();
    mdl_reset();
    exp_q.delete();
    got_q.delete();
    send_done = 1'b0;
    mon_en    = 1'b1;
    fork
      begin
        int len;
        int wt;
        logic [7:0] d;
        for (int t = 0; t < 40; t++) begin
          len = $urandom_range(1, 9);
          for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            wt = 0;
            while (ebus_hold && wt < 500) begin
              tick();
              wt++;
            end
            if (wt >= 500) hold_timeouts++;
            d = 8'($urandom);
            send_byte(d, (b == len - 1));
            mdl_byte(d, (b == len - 1));
          end
        end
        send_done = 1'b1;
      end
      begin
        while (!send_done) begin
          rx_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    rx_ready = 1'b1;
    for (int n = 0; n < 200 && got_q.size() < exp_q.size(); n++) tick();
    tick();
    mon_en = 1'b0;
    checks++;
    if (hold_timeouts != 0) begin
      errors++;
      $display("FAIL rand_hold_timeout got=%0d exp=0", hold_timeouts);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_word_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rand_no_overflow got=%b exp=0", rx_overflow);
    end
  endtask

  initial begin
    reset_l     = 1'b0;
    ebus_data   = 8'h00;
    ebus_strobe = 1'b0;
    ebus_last   = 1'b0;
    rx_ready    = 1'b0;
    rx_clear    = 1'b0;
    bad_par     = 1'b0;
    mon_en      = 1'b0;
    send_done   = 1'b0;
    prev_stall  = 1'b0;
    prev_w      = '0;
`ifdef EBUS_RX_PARITY_EN
    ebus_parity = 1'b1;
`endif
    test_reset();
    test_word_latency();
    test_short_transfer();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
`ifdef EBUS_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
